input_mapper: RTL

- Parametrised player-input front end for the arcade top level.
- Converts MiSTer PS/2 key events and HPS joystick words into registered per-player control words.
- Generalised to PLAYERS players and BUTTONS fire buttons.
- Adds behaviour the fixed keyboard decoder lacks: extended-key matching, SOCD resolution, per-button autofire and a fixed-width coin pulse.
- Output feeds the core's joystick/service inputs.

---
 rtl/input_pkg.sv | 76 +++++++
 rtl/input_channel.sv | 114 +++++++++++
 rtl/input_mapper.sv | 104 ++++++++++
 3 files changed

// File: rtl/input_pkg.sv
// Shared definitions for the player-input front end: word layout, keymap,
// service key codes and the SOCD mode encoding.
package input_pkg;

  // Function indices into the full-size keymap (up to 6 buttons).
  localparam int FN_RIGHT    = 0;
  localparam int FN_LEFT     = 1;
  localparam int FN_DOWN     = 2;
  localparam int FN_UP       = 3;
  localparam int FN_BTN1     = 4;
  localparam int FN_START    = 10;
  localparam int FN_COIN     = 11;
  localparam int FN_PAUSE    = 12;
  localparam int MAX_BUTTONS = 6;

  // {ext, code}; 000 marks an unused entry that never matches.
  localparam logic [8:0] KEY_NONE  = 9'h000;
  localparam logic [8:0] SVC1_CODE = 9'h046;
  localparam logic [8:0] SVC2_CODE = 9'h045;

  typedef enum logic [1:0] {
    SOCD_PASS    = 2'd0,
    SOCD_NEUTRAL = 2'd1,
    SOCD_LAST    = 2'd2,
    SOCD_RSVD    = 2'd3
  } socd_mode_e;

  // Control word width for a given button count.
  function automatic int joy_w(input int buttons);
    return buttons + 7;
  endfunction

  // Map a bit position of the control word to its keymap function index.
  function automatic int bit_fn(input int b, input int buttons);
    if (b < FN_BTN1 + buttons) return b;
    else if (b == FN_BTN1 + buttons) return FN_START;
    else if (b == FN_BTN1 + buttons + 1) return FN_COIN;
    else return FN_PAUSE;
  endfunction

  // Keymap: {ext, scancode} for a player/function pair.
  function automatic logic [8:0] key_code(input int p, input int fn);
    logic [8:0] code;
    code = KEY_NONE;
    case (p)
      0: case (fn)
           FN_UP:     code = 9'h175;
           FN_DOWN:   code = 9'h172;
           FN_LEFT:   code = 9'h16B;
           FN_RIGHT:  code = 9'h174;
           FN_BTN1:   code = 9'h014;
           5:         code = 9'h011;
           6:         code = 9'h029;
           FN_START:  code = 9'h016;
           FN_COIN:   code = 9'h02E;
           FN_PAUSE:  code = 9'h04D;
           default:   code = KEY_NONE;
         endcase
      1: case (fn)
           FN_UP:     code = 9'h02D;
           FN_DOWN:   code = 9'h02B;
           FN_LEFT:   code = 9'h023;
           FN_RIGHT:  code = 9'h034;
           FN_BTN1:   code = 9'h01C;
           5:         code = 9'h01B;
           6:         code = 9'h015;
           FN_START:  code = 9'h01E;
           FN_COIN:   code = 9'h036;
           default:   code = KEY_NONE;
         endcase
      default: code = KEY_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/input_channel.sv
// One player channel: SOCD resolution on both axes, autofire gating of the
// fire buttons and a fixed-width coin pulse stretcher. Output is registered.
module input_channel
  import input_pkg::*;
#(
  parameter int BUTTONS    = 3,
  parameter int COIN_PULSE = 4800000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [joy_w(BUTTONS)-1:0]    i_raw,
  input  logic [1:0]                   i_socd,
  input  logic [BUTTONS-1:0]           i_af_en,
  input  logic                         i_phase,
  output logic [joy_w(BUTTONS)-1:0]    o_word
);

  localparam int JOY_W   = joy_w(BUTTONS);
  localparam int START_B = FN_BTN1 + BUTTONS;
  localparam int COIN_B  = START_B + 1;
  localparam int PAUSE_B = START_B + 2;
  localparam int CW      = $clog2(COIN_PULSE + 1);

  logic [3:0]       r_hist;      // previous raw directions, for edge detection
  logic [1:0]       r_last;      // per axis: 0 = right/down last, 1 = left/up last
  logic [1:0]       r_tie;       // per axis: simultaneous press, hold neutral
  logic [JOY_W-1:0] r_word;
  logic [CW-1:0]    r_coin_cnt;
  logic             r_coin_prev;

  logic [1:0]       w_last_nxt;
  logic [1:0]       w_tie_nxt;
  logic [3:0]       w_dir;
  logic [JOY_W-1:0] w_word;
  logic             w_a, w_b, w_rise_a, w_rise_b;
  logic             w_coin_on;

  // SOCD: update last-pressed history and resolve opposing directions.
  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    w_last_nxt = r_last;
    w_tie_nxt  = r_tie;
    w_dir      = i_raw[3:0];
    w_a        = 1'b0;
    w_b        = 1'b0;
    w_rise_a   = 1'b0;
    w_rise_b   = 1'b0;
    for (int ax = 0; ax < 2; ax++) begin
      w_a      = i_raw[2*ax];
      w_b      = i_raw[2*ax+1];
      w_rise_a = w_a & ~r_hist[2*ax];
      w_rise_b = w_b & ~r_hist[2*ax+1];
      if (w_rise_a && w_rise_b) begin
        w_tie_nxt[ax] = 1'b1;
      end else if (w_rise_a) begin
        w_last_nxt[ax] = 1'b0;
        w_tie_nxt[ax]  = 1'b0;
      end else if (w_rise_b) begin
        w_last_nxt[ax] = 1'b1;
        w_tie_nxt[ax]  = 1'b0;
      end else if (!(w_a && w_b)) begin
        w_tie_nxt[ax] = 1'b0;
      end
      if (w_a && w_b) begin
        case (socd_mode_e'(i_socd))
          SOCD_NEUTRAL: w_dir[2*ax +: 2] = 2'b00;
          SOCD_LAST:    w_dir[2*ax +: 2] = w_tie_nxt[ax]  ? 2'b00 :
                                           w_last_nxt[ax] ? 2'b10 : 2'b01;
          default:      w_dir[2*ax +: 2] = 2'b11;
        endcase
      end
    end
  end

  // Assemble the next control word: directions, gated buttons, start, pause.
  always_comb begin
    w_word        = '0;
    w_word[3:0]   = w_dir;
    for (int i = 0; i < BUTTONS; i++) begin
      w_word[FN_BTN1+i] = i_raw[FN_BTN1+i] & (i_phase | ~i_af_en[i]);
    end
    w_word[START_B] = i_raw[START_B];
    w_word[PAUSE_B] = i_raw[PAUSE_B];
  end

  // Register the word, SOCD history and the coin stretcher.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_hist      <= '0;
      r_last      <= '0;
      r_tie       <= '0;
      r_word      <= '0;
      r_coin_cnt  <= '0;
      r_coin_prev <= 1'b0;
    end else begin
      r_hist      <= i_raw[3:0];
      r_last      <= w_last_nxt;
      r_tie       <= w_tie_nxt;
      r_word      <= w_word;
      r_coin_prev <= i_raw[COIN_B];
      // An active pulse runs to completion; edges seen meanwhile are dropped.
      if (r_coin_cnt != '0) begin
        r_coin_cnt <= r_coin_cnt - 1'b1;
      end else if (i_raw[COIN_B] && !r_coin_prev) begin
        r_coin_cnt <= CW'(COIN_PULSE);
      end
    end
  end

  assign w_coin_on = (r_coin_cnt != '0);
  assign o_word    = r_word | ({{(JOY_W-1){1'b0}}, w_coin_on} << COIN_B);

endmodule

// File: rtl/input_mapper.sv
// Player-input front end: decodes PS/2 key events into key latches, merges
// them with HPS joystick words and drives one input_channel per player.
module input_mapper
  import input_pkg::*;
#(
  parameter int PLAYERS      = 2,
  parameter int BUTTONS      = 3,
  parameter int AUTOFIRE_DIV = 1600000,
  parameter int COIN_PULSE   = 4800000
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [10:0]                         ps2_key,
  input  logic [PLAYERS*joy_w(BUTTONS)-1:0]   joystick,
  input  logic [1:0]                          opt_socd,
  input  logic [PLAYERS*BUTTONS-1:0]          opt_autofire,
  output logic [PLAYERS*joy_w(BUTTONS)-1:0]   player,
  output logic [1:0]                          service
);

  localparam int JOY_W = joy_w(BUTTONS);
  localparam int NB    = PLAYERS * JOY_W;
  localparam int AW    = $clog2(AUTOFIRE_DIV);

  logic          r_prev;
  logic [NB-1:0] r_key;
  logic [1:0]    r_svc;
  logic [1:0]    r_service;
  logic [AW-1:0] r_af_cnt;
  logic          r_phase;

  logic          w_event;
  logic [NB-1:0] w_match;
  logic [1:0]    w_svc_match;
  logic [NB-1:0] w_raw;

  assign w_event = (r_prev != ps2_key[10]);

  // Compare the current key against every keymap entry; 000 entries never match.
  always_comb begin
    w_match = '0;
    for (int p = 0; p < PLAYERS; p++) begin
      for (int b = 0; b < JOY_W; b++) begin
        w_match[p*JOY_W + b] = (key_code(p, bit_fn(b, BUTTONS)) != KEY_NONE) &&
                               (key_code(p, bit_fn(b, BUTTONS)) == ps2_key[8:0]);
      end
    end
    w_svc_match[0] = (ps2_key[8:0] == SVC1_CODE);
    w_svc_match[1] = (ps2_key[8:0] == SVC2_CODE);
  end

  // Key latches and service output; prev tracks the toggle even in reset.
  // NOTE: the key latches are a flop vector, not a RAM, so they are cleared on reset.
  always_ff @(posedge clock) begin
    r_prev <= ps2_key[10];
    if (reset) begin
      r_key     <= '0;
      r_svc     <= '0;
      r_service <= '0;
    end else begin
      if (w_event) begin
        for (int i = 0; i < NB; i++) begin
          if (w_match[i]) r_key[i] <= ps2_key[9];
        end
        for (int s = 0; s < 2; s++) begin
          if (w_svc_match[s]) r_svc[s] <= ps2_key[9];
        end
      end
      r_service <= r_svc;
    end
  end

  // Shared autofire timebase: phase flips each time the counter wraps.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_af_cnt <= '0;
      r_phase  <= 1'b1;
    end else if (r_af_cnt == AW'(AUTOFIRE_DIV - 1)) begin
      r_af_cnt <= '0;
      r_phase  <= ~r_phase;
    end else begin
      r_af_cnt <= r_af_cnt + 1'b1;
    end
  end

  assign w_raw   = r_key | joystick;
  assign service = r_service;

  for (genvar p = 0; p < PLAYERS; p++) begin : g_ch
    input_channel #(
      .BUTTONS    (BUTTONS),
      .COIN_PULSE (COIN_PULSE)
    ) u_ch (
      .clock   (clock),
      .reset   (reset),
      .i_raw   (w_raw[p*JOY_W +: JOY_W]),
      .i_socd  (opt_socd),
      .i_af_en (opt_autofire[p*BUTTONS +: BUTTONS]),
      .i_phase (r_phase),
      .o_word  (player[p*JOY_W +: JOY_W])
    );
  end

endmodule
